se2pa_deserializer: RTL and testbench
=====================================

// Module: se2pa_deserializer
// PURPOSE
//  Serial-to-parallel converter, the receive-side counterpart of the 4-word PA2SE serializer.
//  Collects four consecutive nb-bit complex samples (DR/DI) after START into one 4-word frame.
//  Presents the frame on OR/OI with a one-cycle RDY pulse.
//  Sits between serial sample streams and the 4-lane parallel FFT butterfly inputs.
// PARAMETERS
//  nb  16  sample word width (real and imag each); supplied by `FFTsfpw from parameter.vh
//  NW  4   words per frame; localparam, fixed at 4 (2-bit slot counter)
// PORTS
//  CLK      in   1     clock; all logic on posedge
//  RST      in   1     synchronous, active-high reset
//  START    in   1     marks the first sample (slot 0) of a new frame; DR/DI valid this cycle
//  DR       in   nb    serial real sample
//  DI       in   nb    serial imaginary sample
//  OR       out  nb*4  parallel real frame; slot0 in [nb*4-1:nb*3] ... slot3 in [nb-1:0]
//  OI       out  nb*4  parallel imaginary frame; same slot mapping as OR
//  RDY      out  1     one-cycle pulse; OR/OI hold a newly completed frame
//  ERR      out  1     one-cycle pulse; START arrived while a frame was partially collected
// BEHAVIOUR
//  Reset (RST=1 at posedge): OR=0, OI=0, RDY=0, ERR=0, state=IDLE, cnt=0, staging regs=0.
//  States: IDLE (waiting for START) and RUN (collecting or streaming).
//  IDLE: DR/DI are ignored. START=1 -> capture slot0, cnt<=1, go to RUN.
//  RUN: capture DR/DI into slot[cnt] every cycle; cnt<=cnt+1 (mod 4).
//  Streaming: after slot3, collection continues with slot0 of the next frame on the following cycle.
//   - No new START is needed; the block stays in RUN until reset.
//  Frame completion, on the edge that captures slot3:
//   - OR/OI <= {slot0,slot1,slot2,DR} and {slot0,slot1,slot2,DI} atomically.
//   - RDY<=1 for exactly one cycle.
//  Latency: START at cycle t0 -> RDY=1 and new OR/OI visible in cycle t0+4; next RDY at t0+8, ...
//  OR/OI change only on frame completion; otherwise they hold the last complete frame.
//  START while in RUN with cnt!=0 (partial frame):
//   - Discard the staged slots and capture the current sample as slot0; cnt<=1.
//   - ERR<=1 for one cycle; no RDY for the dropped frame.
//   - OR/OI keep the previous complete frame.
//  START while in RUN with cnt==0 (frame boundary): a normal restart; ERR stays 0.
//  START in the same cycle slot3 would be captured: START wins.
//   - The partial frame is dropped with ERR=1 and no RDY.
//  RST mid-frame: all state cleared next edge; no RDY or ERR is emitted for the interrupted frame.
//  RST has priority over START.
//  Width rule: pure data movement; no arithmetic on samples, no sign extension or truncation.
//  Back-to-back with PA2SE: a PA2SE RDY/START-aligned stream reconstructs the original DR/DI frame.
// STRUCTURE
//  Shared header parameter.vh: nb via `FFTsfpw; slot-index constants (SLOT0..SLOT3) if needed.
//  Single flat module: 2-bit cnt, 1-bit state, 3x2 nb-bit staging regs, 2 output regs, RDY/ERR flops.
//  No sub-module is warranted.
// TESTING (nb=16)
//  1 Reset: hold RST 2 cycles with random DR/DI -> OR=OI=0, RDY=0, ERR=0; no RDY for 10 idle cycles.
//  2 Single frame: START with DR=0x1111,0x2222,0x3333,0x4444 on t0..t0+3 (DI=~DR)
//     -> at t0+4: RDY=1, OR=0x1111_2222_3333_4444, OI=0xEEEE_DDDD_CCCC_BBBB; RDY=0 at t0+5.
//  3 Streaming: START once, then 12 samples 0x0001..0x000C
//     -> RDY pulses at t0+4, t0+8, t0+12; last OR=0x0009_000A_000B_000C.
//  4 Mid-frame START: START with 0xA001,0xA002, then START with 0xB001..0xB004
//     -> ERR=1 one cycle after the 2nd START; no RDY for the A frame;
//     -> RDY 4 cycles after the 2nd START with OR=0xB001_B002_B003_B004.
//  5 Reset mid-frame: START, 2 samples, RST=1 for 1 cycle -> no RDY/ERR, OR/OI=0, state IDLE.
//     -> A later START frame completes normally.
//  6 Loopback: PA2SE -> se2pa_deserializer on random 4-word frames, START aligned to serializer output.
//     -> 100 frames are reconstructed bit-exact.

Source files
------------

// File: rtl/se2pa_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : se2pa_deserializer_pkg
//  Purpose  : Shared types and constants for the 4-word serial-to-parallel
//             sample deserializer.
//  Revision : 1.0  initial release
// ============================================================================
package se2pa_deserializer_pkg;

  localparam int unsigned c_NB_DEFAULT = 16;
  localparam int unsigned c_NW         = 4;
  localparam int unsigned c_CNT_W      = 2;

  localparam logic [c_CNT_W-1:0] c_SLOT0 = 2'd0;
  localparam logic [c_CNT_W-1:0] c_SLOT1 = 2'd1;
  localparam logic [c_CNT_W-1:0] c_SLOT2 = 2'd2;
  localparam logic [c_CNT_W-1:0] c_SLOT3 = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // The slot counter wraps naturally, so streaming needs no special case.
  function automatic logic [c_CNT_W-1:0] next_slot(input logic [c_CNT_W-1:0] slot);
    return slot + 2'd1;
  endfunction

endpackage : se2pa_deserializer_pkg
`default_nettype wire

// File: rtl/se2pa_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : se2pa_deserializer
//  Purpose  : Collects four serial complex samples into one parallel frame,
//             flagging frames torn by an early START.
//  Revision : 1.0  initial release
// ============================================================================
module se2pa_deserializer
  import se2pa_deserializer_pkg::*;
#(
  parameter int NB = c_NB_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [NB-1:0]        DR,
  input  logic [NB-1:0]        DI,
  output logic [NB*c_NW-1:0]   OR,
  output logic [NB*c_NW-1:0]   OI,
  output logic                 RDY,
  output logic                 ERR
);

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [NB-1:0]          r_sr0, r_sr1, r_sr2;
  logic [NB-1:0]          r_si0, r_si1, r_si2;
  logic [NB*c_NW-1:0]     r_or, r_oi;
  logic                   r_rdy, r_err;

  logic                   w_partial;

  assign w_partial = (r_cnt != c_SLOT0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= c_SLOT0;
      r_sr0   <= '0;
      r_sr1   <= '0;
      r_sr2   <= '0;
      r_si0   <= '0;
      r_si1   <= '0;
      r_si2   <= '0;
      r_or    <= '0;
      r_oi    <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_sr0   <= DR;
            r_si0   <= DI;
            r_cnt   <= c_SLOT1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (START) begin
            // An early START abandons the staged slots; the output frame is untouched.
            r_sr0 <= DR;
            r_si0 <= DI;
            r_cnt <= c_SLOT1;
            r_err <= w_partial;
          end else begin
            case (r_cnt)
              c_SLOT0: begin
                r_sr0 <= DR;
                r_si0 <= DI;
              end
              c_SLOT1: begin
                r_sr1 <= DR;
                r_si1 <= DI;
              end
              c_SLOT2: begin
                r_sr2 <= DR;
                r_si2 <= DI;
              end
              c_SLOT3: begin
                r_or  <= {r_sr0, r_sr1, r_sr2, DR};
                r_oi  <= {r_si0, r_si1, r_si2, DI};
                r_rdy <= 1'b1;
              end
            endcase
            r_cnt <= next_slot(r_cnt);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= c_SLOT0;
        end
      endcase
    end
  end

  assign OR  = r_or;
  assign OI  = r_oi;
  assign RDY = r_rdy;
  assign ERR = r_err;

endmodule : se2pa_deserializer
`default_nettype wire

// File: tb/tb_se2pa_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_se2pa_deserializer
//  Purpose  : Directed scoreboard bench for se2pa_deserializer (NB = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_se2pa_deserializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] DR = '0;
  logic [15:0] DI = '0;
  logic [63:0] OR;
  logic [63:0] OI;
  logic        RDY;
  logic        ERR;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [63:0] r;
    logic [63:0] i;
  } exp_t;

  exp_t frame_q[$];
  int   err_q[$];

  se2pa_deserializer #(.NB(16)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .DR    (DR),
    .DI    (DI),
    .OR    (OR),
    .OI    (OI),
    .RDY   (RDY),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every RDY/ERR pulse must match the head of its expectation queue.
  always @(negedge CLK) begin
    if (RDY === 1'b1) begin
      vectors++;
      if (frame_q.size() == 0) begin
        miscompares++;
        $display("FAIL rdy_unexpected: RDY at cycle %0d OR=%h OI=%h, required no RDY", cyc, OR, OI);
      end else begin
        exp_t e;
        e = frame_q.pop_front();
        if (e.cyc != cyc || OR !== e.r || OI !== e.i) begin
          miscompares++;
          $display("FAIL frame: cycle %0d OR=%h OI=%h, required cycle %0d OR=%h OI=%h",
                   cyc, OR, OI, e.cyc, e.r, e.i);
        end
      end
    end
    if (ERR === 1'b1) begin
      vectors++;
      if (err_q.size() == 0) begin
        miscompares++;
        $display("FAIL err_unexpected: ERR at cycle %0d, required no ERR", cyc);
      end else begin
        int ec;
        ec = err_q.pop_front();
        if (ec != cyc) begin
          miscompares++;
          $display("FAIL err_cycle: ERR at cycle %0d, required cycle %0d", cyc, ec);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send(input logic st, input logic [15:0] dr, input logic [15:0] di);
    START = st;
    DR    = dr;
    DI    = di;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_frame(input int c, input logic [63:0] r, input logic [63:0] i);
    exp_t e;
    e.cyc = c;
    e.r   = r;
    e.i   = i;
    frame_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    RST   = 1'b1;
    START = 1'b1;
    for (int k = 0; k < n; k++) begin
      DR = 16'($urandom);
      DI = 16'($urandom);
      @(posedge CLK);
      #1;
    end
    RST   = 1'b0;
    START = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_or"},  OR, 64'h0);
    chk({tag, "_oi"},  OI, 64'h0);
    chk({tag, "_rdy"}, {63'b0, RDY}, 64'h0);
    chk({tag, "_err"}, {63'b0, ERR}, 64'h0);
  endtask

  initial begin
    int t0;
    int t1;
    logic [15:0] w [4];
    logic [15:0] v [4];

    // Reset held two cycles with START asserted: reset must dominate.
    do_reset(2);
    chk_cleared("reset");
    for (int k = 0; k < 10; k++) send(1'b0, 16'($urandom), 16'($urandom));

    // Single frame
    t0 = cyc;
    expect_frame(t0 + 4, 64'h1111_2222_3333_4444, 64'hEEEE_DDDD_CCCC_BBBB);
    send(1'b1, 16'h1111, ~16'h1111);
    send(1'b0, 16'h2222, ~16'h2222);
    send(1'b0, 16'h3333, ~16'h3333);
    send(1'b0, 16'h4444, ~16'h4444);
    send(1'b0, 16'h0000, 16'h0000);
    do_reset(1);

    // Streaming: one START, three frames
    t0 = cyc;
    expect_frame(t0 + 4,  64'h0001_0002_0003_0004, 64'hFFFE_FFFD_FFFC_FFFB);
    expect_frame(t0 + 8,  64'h0005_0006_0007_0008, 64'hFFFA_FFF9_FFF8_FFF7);
    expect_frame(t0 + 12, 64'h0009_000A_000B_000C, 64'hFFF6_FFF5_FFF4_FFF3);
    for (int k = 1; k <= 12; k++) send(k == 1, 16'(k), ~16'(k));
    do_reset(1);

    // START mid-frame drops the A frame
    send(1'b1, 16'hA001, 16'h5001);
    send(1'b0, 16'hA002, 16'h5002);
    t1 = cyc;
    err_q.push_back(t1 + 1);
    expect_frame(t1 + 4, 64'hB001_B002_B003_B004, 64'h6001_6002_6003_6004);
    send(1'b1, 16'hB001, 16'h6001);
    send(1'b0, 16'hB002, 16'h6002);
    send(1'b0, 16'hB003, 16'h6003);
    send(1'b0, 16'hB004, 16'h6004);

    // START at the frame boundary is a clean restart, then reset mid-frame
    send(1'b1, 16'hC001, 16'h7001);
    send(1'b0, 16'hC002, 16'h7002);
    do_reset(1);
    chk_cleared("midrst");
    send(1'b0, 16'h9999, 16'h9999);
    t0 = cyc;
    expect_frame(t0 + 4, 64'hD001_D002_D003_D004, 64'h8001_8002_8003_8004);
    send(1'b1, 16'hD001, 16'h8001);
    send(1'b0, 16'hD002, 16'h8002);
    send(1'b0, 16'hD003, 16'h8003);
    send(1'b0, 16'hD004, 16'h8004);
    do_reset(1);

    // START in the slot-3 cycle wins over completion
    send(1'b1, 16'hE001, 16'h1E01);
    send(1'b0, 16'hE002, 16'h1E02);
    send(1'b0, 16'hE003, 16'h1E03);
    t1 = cyc;
    err_q.push_back(t1 + 1);
    expect_frame(t1 + 4, 64'hF001_F002_F003_F004, 64'h1F01_1F02_1F03_1F04);
    send(1'b1, 16'hF001, 16'h1F01);
    send(1'b0, 16'hF002, 16'h1F02);
    send(1'b0, 16'hF003, 16'h1F03);
    send(1'b0, 16'hF004, 16'h1F04);
    do_reset(1);

    // Loopback: a serializer emits random 4-word frames back to back, START on word 0
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 4; k++) begin
        w[k] = 16'($urandom);
        v[k] = 16'($urandom);
      end
      t0 = cyc;
      expect_frame(t0 + 4, {w[0], w[1], w[2], w[3]}, {v[0], v[1], v[2], v[3]});
      for (int k = 0; k < 4; k++) send(k == 0, w[k], v[k]);
    end
    do_reset(1);

    for (int k = 0; k < 6; k++) send(1'b0, 16'($urandom), 16'($urandom));
    chk("frames_outstanding", 64'(frame_q.size()), 64'h0);
    chk("errs_outstanding",   64'(err_q.size()),   64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_se2pa_deserializer
`default_nettype wire
